cpu_run_monitor: RTL

//   Synthesizable run-control and trace block for the MIPS core. It gates CPU execution
//   (start, cycle limit, PC breakpoints, external halt) and records {PC, instruction} into a

---
 rtl/cpu_run_monitor_if.sv | 33 +++
 rtl/cpu_run_monitor.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor_if.sv
// Bus between the run monitor and its CPU, regfile and trace/dump consumers.
// The master side is the monitor; the slave side is the CPU/regfile/host.
interface cpu_run_monitor_if #(
    parameter int TRACE_DEPTH = 16
);
    localparam int TRACE_AW = $clog2(TRACE_DEPTH);

    logic [31:0]         pc;
    logic [31:0]         instr;
    logic                cpu_stall;
    logic [4:0]          rf_raddr;
    logic [31:0]         rf_rdata;
    logic                trace_rd_en;
    logic [63:0]         trace_rd_data;
    logic [TRACE_AW:0]   trace_count;
    logic                trace_empty;
    logic                dump_valid;
    logic [4:0]          dump_idx;
    logic [31:0]         dump_data;
    logic                dump_done;

    modport master (
        input  pc, instr, rf_rdata, trace_rd_en,
        output cpu_stall, rf_raddr, trace_rd_data, trace_count, trace_empty,
               dump_valid, dump_idx, dump_data, dump_done
    );

    modport slave (
        output pc, instr, rf_rdata, trace_rd_en,
        input  cpu_stall, rf_raddr, trace_rd_data, trace_count, trace_empty,
               dump_valid, dump_idx, dump_data, dump_done
    );
endinterface

// File: rtl/cpu_run_monitor.sv
// Run control for the MIPS core: gates execution on start/limit/breakpoint/halt,
// keeps a circular {pc, instr} trace and streams the regfile out after a halt.
module cpu_run_monitor #(
    parameter int NUM_BP      = 2,
    parameter int TRACE_DEPTH = 16,
    parameter int CYCLE_W     = 16,
    localparam int TRACE_AW   = $clog2(TRACE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  halt_req,
    input  logic [CYCLE_W-1:0]    cfg_max_cycles,
    input  logic [NUM_BP-1:0]     bp_en,
    input  logic [NUM_BP*32-1:0]  bp_addr,
    output logic [1:0]            state,
    output logic [1:0]            halt_cause,
    output logic [CYCLE_W-1:0]    cycle_cnt,
    cpu_run_monitor_if.master     bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2, S_DUMP = 2'd3} state_t;
    typedef enum logic [1:0] {C_NONE = 2'd0, C_BP = 2'd1, C_LIMIT = 2'd2, C_EXT = 2'd3} cause_t;

    localparam logic [TRACE_AW:0] FULL_COUNT = (TRACE_AW+1)'(TRACE_DEPTH);

    state_t              st_q;
    cause_t              cause_q;
    logic [CYCLE_W-1:0]  cnt_q;
    logic [CYCLE_W-1:0]  limit_q;
    logic [TRACE_AW-1:0] wr_ptr_q;
    logic [TRACE_AW-1:0] rd_ptr_q;
    logic [TRACE_AW:0]   count_q;
    logic [4:0]          raddr_q;
    logic                dump_valid_q;
    logic [4:0]          dump_idx_q;
    logic [31:0]         dump_data_q;
    logic                dump_done_q;
    logic [63:0]         trace_mem [TRACE_DEPTH];

    logic                bp_any;
    logic                bp_hit;
    logic                trace_wr;
    logic                pop;
    logic                start_run;
    logic [CYCLE_W:0]    cnt_plus;
    logic [CYCLE_W-1:0]  cnt_sat;
    logic                limit_hit;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        bp_any = 1'b0;
        for (int k = 0; k < NUM_BP; k++) begin
            if (bp_en[k] && (bus.pc == bp_addr[32*k +: 32])) bp_any = 1'b1;
        end
    end

    assign bp_hit    = (st_q == S_RUN) && bp_any;
    assign trace_wr  = (st_q == S_RUN) && !bp_any;
    assign start_run = (st_q == S_IDLE) && start;
    assign pop       = bus.trace_rd_en && (st_q != S_RUN) && (count_q != '0) && !start_run;

    // Widened compare so a saturated counter can never alias onto the limit.
    assign cnt_plus  = {1'b0, cnt_q} + 1'b1;
    assign cnt_sat   = (&cnt_q) ? cnt_q : cnt_plus[CYCLE_W-1:0];
    assign limit_hit = (limit_q != '0) && (cnt_plus == {1'b0, limit_q});

    // NOTE: the trace storage has no reset; the cleared pointers/count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (trace_wr) trace_mem[wr_ptr_q] <= {bus.pc, bus.instr};
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q         <= S_IDLE;
            cause_q      <= C_NONE;
            cnt_q        <= '0;
            limit_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            raddr_q      <= '0;
            dump_valid_q <= 1'b0;
            dump_idx_q   <= '0;
            dump_data_q  <= '0;
            dump_done_q  <= 1'b0;
        end else begin
            dump_valid_q <= 1'b0;
            dump_done_q  <= 1'b0;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q  <= count_q - 1'b1;
            end
            case (st_q)
                S_IDLE: begin
                    if (start) begin
                        st_q     <= S_RUN;
                        cause_q  <= C_NONE;
                        cnt_q    <= '0;
                        limit_q  <= cfg_max_cycles;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        count_q  <= '0;
                    end
                end
                S_RUN: begin
                    if (bp_hit) begin
                        st_q    <= S_HALT;
                        cause_q <= C_BP;
                    end else begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        cnt_q    <= cnt_sat;
                        // A full buffer drops its oldest entry to make room.
                        if (count_q == FULL_COUNT) rd_ptr_q <= rd_ptr_q + 1'b1;
                        else                       count_q  <= count_q + 1'b1;
                        if (limit_hit) begin
                            st_q    <= S_HALT;
                            cause_q <= C_LIMIT;
                        end else if (halt_req) begin
                            st_q    <= S_HALT;
                            cause_q <= C_EXT;
                        end
                    end
                end
                S_HALT: begin
                    st_q    <= S_DUMP;
                    raddr_q <= '0;
                end
                S_DUMP: begin
                    dump_valid_q <= 1'b1;
                    dump_idx_q   <= raddr_q;
                    dump_data_q  <= (raddr_q == 5'd0) ? 32'd0 : bus.rf_rdata;
                    raddr_q      <= raddr_q + 1'b1;
                    if (raddr_q == 5'd31) begin
                        dump_done_q <= 1'b1;
                        st_q        <= S_IDLE;
                    end
                end
                default: st_q <= S_IDLE;
            endcase
        end
    end

    assign state             = st_q;
    assign halt_cause        = cause_q;
    assign cycle_cnt         = cnt_q;
    assign bus.cpu_stall     = (st_q != S_RUN) || bp_hit;
    assign bus.rf_raddr      = raddr_q;
    assign bus.trace_rd_data = trace_mem[rd_ptr_q];
    assign bus.trace_count   = count_q;
    assign bus.trace_empty   = (count_q == '0);
    assign bus.dump_valid    = dump_valid_q;
    assign bus.dump_idx      = dump_idx_q;
    assign bus.dump_data     = dump_data_q;
    assign bus.dump_done     = dump_done_q;
endmodule
